// File: rtl/sccb_reg_sequencer_if.sv
// Command/data stream bundle between the register sequencer and an external i2c_master.
// Handshake rule: a transfer happens on a rising clk where valid && ready; valid never drops before that.
interface sccb_reg_sequencer_if;
  logic [6:0] cmd_address;
  logic       cmd_start;
  logic       cmd_read;
  logic       cmd_write;
  logic       cmd_write_multiple;
  logic       cmd_stop;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] data_tdata;
  logic       data_tvalid;
  logic       data_tready;
  logic       data_tlast;
  logic       busy_in;
  logic       missed_ack_in;

  modport master (
    output cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid,
    input  cmd_ready,
    output data_tdata, data_tvalid, data_tlast,
    input  data_tready, busy_in, missed_ack_in
  );

  modport slave (
    input  cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid,
    output cmd_ready,
    input  data_tdata, data_tvalid, data_tlast,
    output data_tready, busy_in, missed_ack_in
  );
endinterface

// File: rtl/sccb_reg_sequencer.sv
// Walks a register script in BRAM and writes each entry to an SCCB device through i2c_master,
// handling delay entries, retries on missed ACK, error reporting and a completion pulse.
module sccb_reg_sequencer #(
  parameter int         RAM_DEPTH     = 256,
  parameter logic [6:0] DEV_ADDR      = 7'h3C,
  parameter int         REGADDR_BYTES = 2,
  parameter int         BRAM_LATENCY  = 2,
  parameter int         MAX_RETRIES   = 3,
  parameter int         DELAY_UNIT    = 100000,
  localparam int        AW            = $clog2(RAM_DEPTH),
  localparam int        EW            = 8 * REGADDR_BYTES + 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [AW-1:0]        start_addr,
  output logic [AW-1:0]        bram_addr,
  input  logic [EW-1:0]        bram_dout,
  sccb_reg_sequencer_if.master i2c,
  output logic                 done,
  output logic                 error,
  output logic [AW-1:0]        error_index,
  output logic [AW:0]          entries_written,
  output logic [2:0]           dbg_state
);

  localparam int LW = $clog2(BRAM_LATENCY + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_RAM, S_DECODE, S_ISSUE_CMD, S_WRITE_BYTE, S_WAIT_IDLE, S_DELAY
  } state_t;

  state_t        r_state, w_state;
  logic [AW-1:0] r_bram_addr, w_bram_addr;
  logic [EW-1:0] r_entry, w_entry;
  logic [LW-1:0] r_lat_cnt, w_lat_cnt;
  logic [31:0]   r_delay_cnt, w_delay_cnt;
  logic [1:0]    r_byte_idx, w_byte_idx;
  logic [RW-1:0] r_retry, w_retry;
  logic          r_missed, w_missed;
  logic          r_seen_busy, w_seen_busy;
  logic [AW:0]   r_entry_cnt, w_entry_cnt;
  logic [AW:0]   r_written, w_written;
  logic          r_error, w_error;
  logic [AW-1:0] r_error_index, w_error_index;
  logic          r_done, w_done;
  logic          w_advance;
  logic [EW-1:0] w_shift;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= S_IDLE;
      r_bram_addr   <= '0;
      r_entry       <= '0;
      r_lat_cnt     <= '0;
      r_delay_cnt   <= '0;
      r_byte_idx    <= '0;
      r_retry       <= '0;
      r_missed      <= 1'b0;
      r_seen_busy   <= 1'b0;
      r_entry_cnt   <= '0;
      r_written     <= '0;
      r_error       <= 1'b0;
      r_error_index <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_bram_addr   <= w_bram_addr;
      r_entry       <= w_entry;
      r_lat_cnt     <= w_lat_cnt;
      r_delay_cnt   <= w_delay_cnt;
      r_byte_idx    <= w_byte_idx;
      r_retry       <= w_retry;
      r_missed      <= w_missed;
      r_seen_busy   <= w_seen_busy;
      r_entry_cnt   <= w_entry_cnt;
      r_written     <= w_written;
      r_error       <= w_error;
      r_error_index <= w_error_index;
      r_done        <= w_done;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_bram_addr   = r_bram_addr;
    w_entry       = r_entry;
    w_lat_cnt     = r_lat_cnt;
    w_delay_cnt   = r_delay_cnt;
    w_byte_idx    = r_byte_idx;
    w_retry       = r_retry;
    w_missed      = r_missed;
    w_seen_busy   = r_seen_busy;
    w_entry_cnt   = r_entry_cnt;
    w_written     = r_written;
    w_error       = r_error;
    w_error_index = r_error_index;
    w_done        = 1'b0;
    w_advance     = 1'b0;

    // Bus status is tracked for the whole life of one send attempt.
    if (r_state inside {S_ISSUE_CMD, S_WRITE_BYTE, S_WAIT_IDLE}) begin
      w_missed    = r_missed | i2c.missed_ack_in;
      w_seen_busy = r_seen_busy | i2c.busy_in;
    end

    case (r_state)
      S_IDLE: begin
        if (start_valid) begin
          w_state     = S_FETCH;
          w_bram_addr = start_addr;
          w_error     = 1'b0;
          w_written   = '0;
          w_entry_cnt = '0;
          w_retry     = '0;
        end
      end
      S_FETCH: begin
        w_lat_cnt = LW'(BRAM_LATENCY - 1);
        w_state   = S_WAIT_RAM;
      end
      S_WAIT_RAM: begin
        if (r_lat_cnt == '0) w_state = S_DECODE;
        else                 w_lat_cnt = r_lat_cnt - 1'b1;
      end
      S_DECODE: begin
        w_entry = bram_dout;
        if (bram_dout == '0) begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end else if (&bram_dout[EW-1:8]) begin
          w_delay_cnt = 32'(bram_dout[7:0]) * 32'(DELAY_UNIT);
          w_state     = S_DELAY;
        end else begin
          w_state = S_ISSUE_CMD;
        end
      end
      S_ISSUE_CMD: begin
        if (i2c.cmd_ready) begin
          w_missed    = i2c.missed_ack_in;
          w_seen_busy = i2c.busy_in;
          w_byte_idx  = '0;
          w_state     = S_WRITE_BYTE;
        end
      end
      S_WRITE_BYTE: begin
        if (i2c.data_tready) begin
          if (r_byte_idx == 2'(REGADDR_BYTES)) w_state = S_WAIT_IDLE;
          else                                 w_byte_idx = r_byte_idx + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (r_seen_busy && !i2c.busy_in) begin
          if (!w_missed) begin
            w_written = r_written + 1'b1;
            w_retry   = '0;
            w_advance = 1'b1;
          end else if (r_retry < RW'(MAX_RETRIES)) begin
            w_retry = r_retry + 1'b1;
            w_state = S_ISSUE_CMD;
          end else begin
            w_error       = 1'b1;
            w_error_index = r_bram_addr;
            w_done        = 1'b1;
            w_state       = S_IDLE;
          end
        end
      end
      S_DELAY: begin
        if (r_delay_cnt == '0) w_advance = 1'b1;
        else                   w_delay_cnt = r_delay_cnt - 1'b1;
      end
      default: w_state = S_IDLE;
    endcase

    // A full lap of the table without a terminator also ends the run.
    if (w_advance) begin
      w_entry_cnt = r_entry_cnt + 1'b1;
      if (r_entry_cnt == (AW+1)'(RAM_DEPTH - 1)) begin
        w_done  = 1'b1;
        w_state = S_IDLE;
      end else begin
        w_bram_addr = (r_bram_addr == AW'(RAM_DEPTH - 1)) ? '0 : r_bram_addr + 1'b1;
        w_state     = S_FETCH;
      end
    end
  end

  assign w_shift = r_entry << {r_byte_idx, 3'b000};

  assign start_ready            = (r_state == S_IDLE) && !rst_in;
  assign bram_addr              = r_bram_addr;
  assign i2c.cmd_address        = DEV_ADDR;
  assign i2c.cmd_valid          = (r_state == S_ISSUE_CMD);
  assign i2c.cmd_start          = i2c.cmd_valid;
  assign i2c.cmd_write_multiple = i2c.cmd_valid;
  assign i2c.cmd_stop           = i2c.cmd_valid;
  assign i2c.cmd_read           = 1'b0;
  assign i2c.cmd_write          = 1'b0;
  assign i2c.data_tvalid        = (r_state == S_WRITE_BYTE);
  assign i2c.data_tdata         = w_shift[EW-1 -: 8];
  assign i2c.data_tlast         = i2c.data_tvalid && (r_byte_idx == 2'(REGADDR_BYTES));
  assign done                   = r_done;
  assign error                  = r_error;
  assign error_index            = r_error_index;
  assign entries_written        = r_written;
  assign dbg_state              = r_state;

endmodule
